// File: rtl/exp_pkg.sv
// Shared definitions for the exponential datapath: reconstruction FSM states,
// default widths and constants common to the selection and reconstruction stages.
package exp_pkg;

  localparam int unsigned Y_W_DEF    = 24;
  localparam int unsigned Y_FRAC_DEF = 14;
  localparam int unsigned IDX_W      = 5;

  // ln2 threshold used by the selection stage
  localparam logic [14:0] LN2_THR = 15'h058B;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACC,
    ST_DONE
  } state_t;

endpackage

// File: rtl/exp_step_alu.sv
// Combinational single-step update for the e^x reconstruction accumulator:
// integer steps shift left, fractional steps add a right-shifted copy, with saturation.
module exp_step_alu
  import exp_pkg::*;
#(
  parameter int unsigned Y_W = Y_W_DEF
) (
  input  logic [Y_W-1:0]   y,
  input  logic [IDX_W-1:0] i,
  input  logic             int_or_fra,
  input  logic             ovf_in,
  output logic [Y_W-1:0]   y_next,
  output logic             ovf_out
);

  // 32 guard bits cover the largest possible left shift (i = 31)
  localparam int unsigned EXT_W = Y_W + 32;

  logic [EXT_W-1:0] y_ext;
  logic [EXT_W-1:0] y_sum;

  always_comb begin
    y_ext = {{32{1'b0}}, y};
    if (int_or_fra) begin
      y_sum = y_ext << i;
    end else begin
      y_sum = y_ext + (y_ext >> i);
    end
    ovf_out = ovf_in | (|y_sum[EXT_W-1:Y_W]);
    y_next  = ovf_out ? '1 : y_sum[Y_W-1:0];
  end

endmodule

// File: rtl/exp_reconstruct.sv
// Sequential e^x reconstruction: accumulates range-reduction steps from 1.0 and
// emits one saturating fixed-point result per start/last transaction.
module exp_reconstruct
  import exp_pkg::*;
#(
  parameter int unsigned Y_W    = Y_W_DEF,
  parameter int unsigned Y_FRAC = Y_FRAC_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             step_valid,
  output logic             step_ready,
  input  logic [IDX_W-1:0] i,
  input  logic             int_or_fra,
  input  logic             last,
  output logic [Y_W-1:0]   y,
  output logic             y_valid,
  output logic             ovf,
  output logic             busy
);

  localparam logic [Y_W-1:0] Y_ONE = Y_W'(1) << Y_FRAC;

  state_t         state, state_nxt;
  logic           load, fire;
  logic [Y_W-1:0] alu_y;
  logic           alu_ovf;

  exp_step_alu #(
    .Y_W(Y_W)
  ) u_alu (
    .y         (y),
    .i         (i),
    .int_or_fra(int_or_fra),
    .ovf_in    (ovf),
    .y_next    (alu_y),
    .ovf_out   (alu_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Handshake outputs decode from state only; start always wins over a step
  always_comb begin
    state_nxt  = state;
    load       = 1'b0;
    fire       = 1'b0;
    step_ready = 1'b0;
    busy       = 1'b0;
    y_valid    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = ST_ACC;
        end
      end
      ST_ACC: begin
        step_ready = 1'b1;
        busy       = 1'b1;
        if (start) begin
          load = 1'b1;
        end else if (step_valid) begin
          fire = 1'b1;
          if (last) begin
            state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        y_valid   = 1'b1;
        state_nxt = ST_IDLE;
        if (start) begin
          load      = 1'b1;
          state_nxt = ST_ACC;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y   <= '0;
      ovf <= 1'b0;
    end else if (load) begin
      y   <= Y_ONE;
      ovf <= 1'b0;
    end else if (fire) begin
      y   <= alu_y;
      ovf <= alu_ovf;
    end
  end

endmodule

// File: doc/exp_reconstruct.md
# exp_reconstruct

Sequential reconstruction stage of the exponential datapath. It consumes the stream of range-reduction decisions produced by the selection stage: a table index `i` plus an `int_or_fra` flag, with 0 meaning fractional and 1 meaning integer. From these it rebuilds e^x by shift-add accumulation, starting from 1.0. It sits downstream of the selection/residual loop and delivers one fixed-point result per `start`/`last` transaction.

## Interface
Parameters:
- `Y_W`, default 24: accumulator and result width.
- `Y_FRAC`, default 14: fractional bits of `y`, so 1.0 = `1 << Y_FRAC`.

Ports:
- `clk` input, 1 bit: single clock, all state on the rising edge.
- `rst_n` input, 1 bit: asynchronous, active-low reset.
- `start` input, 1 bit: begin a new transaction; loads y = 1.0.
- `step_valid` input, 1 bit: a step is presented.
- `step_ready` output, 1 bit: the block accepts a step this cycle.
- `i` input, 5 bits: shift amount / table index of the step.
- `int_or_fra` input, 1 bit: 0 = fractional step, 1 = integer step.
- `last` input, 1 bit: qualifies the final step of a transaction.
- `y` output, `Y_W` bits: unsigned result, `Y_FRAC` fractional bits.
- `y_valid` output, 1 bit: one-cycle pulse marking `y` as final.
- `ovf` output, 1 bit: sticky saturation flag for the current transaction.
- `busy` output, 1 bit: high in ACC.

## Operation
- FSM states: IDLE, ACC, DONE.
- **IDLE:** `step_ready`=0 and steps are ignored. On `start` the block loads y=`1<<Y_FRAC`, clears `ovf` and moves to ACC.
- **ACC:** `step_ready`=1. A step fires on `step_valid & step_ready`. Per fired step:
  - `int_or_fra`=1: y <= y << i, i.e. y·2^i. i=0 is a no-op.
  - `int_or_fra`=0: y <= y + (y >> i), i.e. y·(1+2^-i). i=0 doubles y. For i > `Y_FRAC` the truncated term may be 0; this is legal.
  - If `last`=1 on the fired step, move to DONE.
- **DONE:** lasts one cycle. `y_valid`=1, `step_ready`=0, then return to IDLE.
- **Arithmetic:**
  - Compute at `Y_W+32` bits. If any bit at or above `Y_W` is set, y saturates to all-ones and `ovf` goes to 1.
  - Once `ovf` is set, y stays saturated for the rest of the transaction.
  - Right shift truncates toward zero; no rounding.
- **start in ACC or DONE:** aborts the current transaction and reloads y=1.0 with `ovf`=0. No `y_valid` is issued for the aborted transaction. start has priority over a simultaneous step.
- **start with a simultaneous step in IDLE:** the step is ignored, because `step_ready` is 0 in that cycle.
- `y` holds its last value in IDLE until the next `start`.

## Timing
- **Reset values:** y=0, `y_valid`=0, `ovf`=0, `step_ready`=0, `busy`=0, state=IDLE.
- **Reset mid-transaction:** all outputs go to their reset values immediately (asynchronous). No `y_valid` is issued.
- **Step throughput:** one step per cycle. The updated y is visible the cycle after the handshake.
- **start to ready:** `start` at edge n gives `step_ready`=1 from cycle n+1.
- **Completion:** with `last` accepted at edge n, `y_valid`=1 during cycle n+1 with the final y, and `step_ready`=1 again only after a new `start`.
- `step_ready` depends only on state; there is no combinational path from `step_valid`.

## Structure
- Shared package `exp_pkg` holds:
  - the state enum;
  - `Y_W` and `Y_FRAC` defaults;
  - the ln2 threshold constant 15'h058B shared with the selection stage;
  - the index width (5).
- One sub-module, `exp_step_alu`, purely combinational. It takes (y, i, `int_or_fra`, `ovf_in`) and returns (y_next, `ovf_out`), including the saturation logic. The top level holds the FSM and registers.

## Test plan
- **Single fractional step:** `start`, then one step i=1, `int_or_fra`=0, `last`=1 -> `y_valid` pulse with y=0x006000 (1.5), `ovf`=0.
- **Mixed sequence:** steps (int, i=3) then (fra, i=2, `last`) -> y=0x028000 (8 × 1.25 = 10.0).
- **Overflow:** `start`, then (int, i=10, `last`) -> y=0xFFFFFF, `ovf`=1. A following `start` clears `ovf`.
- **Flow control:** `step_valid` held high in IDLE with no `start` -> `step_ready`=0, y unchanged, no `y_valid`.
- **Abort:** `start`, two fractional steps, then `start` again, then (fra, i=1, `last`) -> y=0x006000 and exactly one `y_valid` pulse.
- **Asynchronous reset:** `rst_n` low mid-ACC between clock edges -> y=0 and `busy`=0 immediately. After release, no steps are accepted until `start`.
